// File: rtl/spike_event_queue_if.sv
// Address-event bus between the spike capture queue and its producer/consumer.
// The slave side is the queue; the master side drives spikes and accepts events.
interface spike_event_queue_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TS_W   = 16
);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned DROP_W = 16;

  logic [31:0]         spike_in;
  logic [ADDR_W-1:0]   source_addr;
  logic [ADDR_W-1:0]   evt_addr;
  logic [TS_W-1:0]     evt_time;
  logic                evt_valid;
  logic                evt_ready;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic [DROP_W-1:0]   drop_count;
  logic                overflow;
  logic                clear_drop;

  modport master (
    output spike_in, source_addr, evt_ready, clear_drop,
    input  evt_addr, evt_time, evt_valid, count, full, drop_count, overflow
  );

  modport slave (
    input  spike_in, source_addr, evt_ready, clear_drop,
    output evt_addr, evt_time, evt_valid, count, full, drop_count, overflow
  );
endinterface

// File: rtl/spike_event_queue.sv
// Spike-to-address-event converter: timestamps each spike with its source
// address, buffers events in a first-word-fall-through FIFO, and counts drops.
module spike_event_queue #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned TS_W      = 16,
  parameter int unsigned EDGE_ONLY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  spike_event_queue_if.slave    io_bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = ADDR_W + TS_W;
  localparam int unsigned DROP_W = 16;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_valid;
  logic              r_full;
  logic [TS_W-1:0]   r_ts;
  logic              r_prev;
  logic [DROP_W-1:0] r_drop;
  logic              r_ovf;

  logic              w_spk;
  logic              w_push_req;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [CNT_W-1:0]  w_count_nxt;

  // Spike detection and push/pop/drop arbitration for this edge.
  always_comb begin
    w_spk       = |io_bus.spike_in;
    w_push_req  = (EDGE_ONLY != 0) ? (w_spk & ~r_prev) : w_spk;
    w_pop       = r_valid & io_bus.evt_ready;
    // A pop on the same edge frees the slot, so a full queue still accepts.
    w_push      = w_push_req & (~r_full | w_pop);
    w_drop      = w_push_req & r_full & ~w_pop;
    w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // Free-running timestamp and previous-spike register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ts   <= '0;
      r_prev <= 1'b0;
    end else begin
      r_ts   <= r_ts + TS_W'(1);
      r_prev <= w_spk;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= {io_bus.source_addr, r_ts};
    end
  end

  // Pointers, occupancy and the status flags derived from the next occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  // Saturating drop counter and sticky overflow; a drop on a clear edge counts once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else if (io_bus.clear_drop) begin
      r_drop <= DROP_W'(w_drop);
      r_ovf  <= w_drop;
    end else if (w_drop) begin
      if (r_drop != {DROP_W{1'b1}}) r_drop <= r_drop + DROP_W'(1);
      r_ovf <= 1'b1;
    end
  end

  assign io_bus.evt_addr   = r_mem[r_rptr][ENT_W-1:TS_W];
  assign io_bus.evt_time   = r_mem[r_rptr][TS_W-1:0];
  assign io_bus.evt_valid  = r_valid;
  assign io_bus.count      = r_count;
  assign io_bus.full       = r_full;
  assign io_bus.drop_count = r_drop;
  assign io_bus.overflow   = r_ovf;
endmodule

// File: tb/tb_spike_event_queue.sv
// Bench for spike_event_queue: two instances (edge mode / 16-bit stamps and
// level mode / 4-bit stamps) share stimulus and are compared against a
// queue-based reference model after every clock.
module tb_spike_event_queue;
  logic clk;
  logic rst;

  spike_event_queue_if #(.DEPTH(16), .ADDR_W(32), .TS_W(16)) bus0 ();
  spike_event_queue_if #(.DEPTH(16), .ADDR_W(32), .TS_W(4))  bus1 ();

  spike_event_queue #(.DEPTH(16), .ADDR_W(32), .TS_W(16), .EDGE_ONLY(1)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus0)
  );

  spike_event_queue #(.DEPTH(16), .ADDR_W(32), .TS_W(4), .EDGE_ONLY(0)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus1)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: one event queue per instance, shared cycle count.
  logic [47:0] q0[$];
  logic [47:0] q1[$];
  int          cyc;
  bit          prev [2];
  int          drop [2];
  bit          ovf  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      prev[k] = 1'b0;
      drop[k] = 0;
      ovf[k]  = 1'b0;
    end
  endtask

  // One clock edge of the event queue seen as: stamp, optional pop, optional push or drop.
  task automatic model_edge(input int k, input logic [31:0] spk, input logic [31:0] addr,
                            input logic rdy, input logic clr);
    bit s, req, pop, dropped;
    int sz;
    logic [15:0] ts;
    s   = (spk != 32'd0);
    req = (k == 0) ? (s && !prev[k]) : s;
    sz  = (k == 0) ? q0.size() : q1.size();
    pop = (sz > 0) && rdy;
    dropped = req && (sz == 16) && !pop;
    ts  = (k == 0) ? 16'(cyc % 65536) : 16'(cyc % 16);
    if (k == 0) begin
      if (pop) void'(q0.pop_front());
      if (req && !dropped) q0.push_back({addr, ts});
    end else begin
      if (pop) void'(q1.pop_front());
      if (req && !dropped) q1.push_back({addr, ts});
    end
    if (clr) begin
      drop[k] = dropped ? 1 : 0;
      ovf[k]  = dropped;
    end else if (dropped) begin
      if (drop[k] < 65535) drop[k]++;
      ovf[k] = 1'b1;
    end
    prev[k] = s;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_i0_count"}, 64'(bus0.count), 64'(q0.size()));
    chk({tag, "_i0_valid"}, 64'(bus0.evt_valid), 64'(q0.size() != 0));
    chk({tag, "_i0_full"},  64'(bus0.full), 64'(q0.size() == 16));
    chk({tag, "_i0_drop"},  64'(bus0.drop_count), 64'(drop[0]));
    chk({tag, "_i0_ovf"},   64'(bus0.overflow), 64'(ovf[0]));
    if (q0.size() != 0) begin
      chk({tag, "_i0_addr"}, 64'(bus0.evt_addr), 64'(q0[0][47:16]));
      chk({tag, "_i0_time"}, 64'(bus0.evt_time), 64'(q0[0][15:0]));
    end
    chk({tag, "_i1_count"}, 64'(bus1.count), 64'(q1.size()));
    chk({tag, "_i1_valid"}, 64'(bus1.evt_valid), 64'(q1.size() != 0));
    chk({tag, "_i1_full"},  64'(bus1.full), 64'(q1.size() == 16));
    chk({tag, "_i1_drop"},  64'(bus1.drop_count), 64'(drop[1]));
    chk({tag, "_i1_ovf"},   64'(bus1.overflow), 64'(ovf[1]));
    if (q1.size() != 0) begin
      chk({tag, "_i1_addr"}, 64'(bus1.evt_addr), 64'(q1[0][47:16]));
      chk({tag, "_i1_time"}, 64'(bus1.evt_time), 64'(q1[0][15:0]));
    end
  endtask

  task automatic drive(input logic [31:0] spk, input logic [31:0] addr,
                       input logic rdy, input logic clr);
    bus0.spike_in = spk;  bus0.source_addr = addr;  bus0.evt_ready = rdy;  bus0.clear_drop = clr;
    bus1.spike_in = spk;  bus1.source_addr = addr;  bus1.evt_ready = rdy;  bus1.clear_drop = clr;
  endtask

  // Apply inputs for one cycle, advance the model on the edge, check on the falling edge.
  task automatic step(input string tag, input logic [31:0] spk, input logic [31:0] addr,
                      input logic rdy, input logic clr);
    drive(spk, addr, rdy, clr);
    @(posedge clk);
    model_edge(0, spk, addr, rdy, clr);
    model_edge(1, spk, addr, rdy, clr);
    cyc++;
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [31:0] spk;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    model_reset();

    // Reset: all outputs zero after release.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all("reset");
    chk("reset_i0_addr", 64'(bus0.evt_addr), 64'd0);
    chk("reset_i0_time", 64'(bus0.evt_time), 64'd0);

    // Alternating spikes with no consumer.
    for (int i = 0; i < 8; i++) step("alt", (i % 2 == 0) ? 32'd1 : 32'd0, 32'h0000_00A5, 1'b0, 1'b0);
    chk("alt_i0_count4", 64'(bus0.count), 64'd4);
    chk("alt_i0_addr_a5", 64'(bus0.evt_addr), 64'hA5);
    for (int i = 0; i < 5; i++) step("alt_drain", 32'd0, 32'd0, 1'b1, 1'b0);

    // Held spike: one event in edge mode, five consecutive in level mode.
    for (int i = 0; i < 5; i++) step("hold", 32'h8000_0000, 32'h11, 1'b0, 1'b0);
    step("hold_end", 32'd0, 32'd0, 1'b0, 1'b0);
    chk("hold_i0_one", 64'(bus0.count), 64'd1);
    chk("hold_i1_five", 64'(bus1.count), 64'd5);
    for (int i = 0; i < 6; i++) step("hold_drain", 32'd0, 32'd0, 1'b1, 1'b0);

    // Fill with 20 events, 4 dropped; then clear the drop state.
    for (int i = 0; i < 40; i++)
      step("fill", (i % 2 == 0) ? 32'd4 : 32'd0, 32'(100 + i), 1'b0, 1'b0);
    chk("fill_i0_drop4", 64'(bus0.drop_count), 64'd4);
    chk("fill_i1_drop4", 64'(bus1.drop_count), 64'd4);
    chk("fill_i0_full", 64'(bus0.full), 64'd1);
    chk("fill_i0_head", 64'(bus0.evt_addr), 64'd100);
    step("clear", 32'd0, 32'd0, 1'b0, 1'b1);
    chk("clear_i0_drop0", 64'(bus0.drop_count), 64'd0);
    chk("clear_i0_ovf0", 64'(bus0.overflow), 64'd0);

    // Full with simultaneous push and pop: no drop, head advances.
    step("fullpp", 32'd1, 32'hBEEF, 1'b1, 1'b0);
    chk("fullpp_i0_count16", 64'(bus0.count), 64'd16);
    chk("fullpp_i0_drop0", 64'(bus0.drop_count), 64'd0);
    step("fullpp_idle", 32'd0, 32'd0, 1'b0, 1'b0);

    // Drop on the same edge as a clear leaves a count of one.
    step("clrdrop", 32'd1, 32'hCAFE, 1'b0, 1'b1);
    chk("clrdrop_i0_drop1", 64'(bus0.drop_count), 64'd1);
    chk("clrdrop_i1_ovf1", 64'(bus1.overflow), 64'd1);
    for (int i = 0; i < 17; i++) step("full_drain", 32'd0, 32'd0, 1'b1, 1'b0);
    step("clear2", 32'd0, 32'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle with five events queued.
    for (int i = 0; i < 5; i++) step("pre_rst", 32'd2, 32'(200 + i), 1'b0, 1'b0);
    chk("pre_rst_i1_count5", 64'(bus1.count), 64'd5);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    #50;
    rst = 1'b1;
    #1;
    chk("async_i1_count0", 64'(bus1.count), 64'd0);
    chk("async_i1_valid0", 64'(bus1.evt_valid), 64'd0);
    chk("async_i0_count0", 64'(bus0.count), 64'd0);
    chk("async_i1_addr0", 64'(bus1.evt_addr), 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("post_rst");

    // Continuous events with a ready consumer: level instance wraps its stamp.
    for (int i = 0; i < 40; i++) begin
      step("wrap", 32'd1, 32'(1000 + i), 1'b1, 1'b0);
      chk("wrap_i1_le1", 64'(bus1.count <= 5'd1), 64'd1);
    end
    for (int i = 0; i < 2; i++) step("wrap_drain", 32'd0, 32'd0, 1'b1, 1'b0);

    // Random spikes, addresses, backpressure and occasional clears.
    for (int i = 0; i < 1000; i++) begin
      spk = ($urandom_range(1, 0) == 1) ? ($urandom | (32'd1 << $urandom_range(31, 0))) : 32'd0;
      step("rand", spk, $urandom, ($urandom_range(3, 0) != 0), ($urandom_range(63, 0) == 0));
    end
    for (int i = 0; i < 17; i++) step("rand_drain", 32'd0, 32'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
